msg_encoder: RTL and testbench
==============================

Name: msg_encoder

Overview:
- Upstream producer for the framing send side.
- Accepts a stream of 32-bit message arguments, VLQ-encodes each one (Klipper-style signed varint) or passes it through as a raw byte, and assembles one message payload in a local buffer.
- On the last argument it copies the payload into the framing send ring, then pushes the payload length into the send length FIFO.
- Oversized messages are dropped whole, so the ring/length pairing never desyncs.

Parameters:
- LEN_BITS, 8, width of send_fifo_data (must match framing)
- MAX_PAYLOAD, 58, maximum payload bytes per frame (frame len = payload+5 < 64)
- BUF_BITS, 6, address width of the local payload buffer (2^BUF_BITS ≥ MAX_PAYLOAD)

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- in_valid  in  1  argument word valid
- in_ready  out  1  encoder accepts a word this cycle
- in_data  in  32  argument, two's complement
- in_raw  in  1  emit in_data[7:0] verbatim as one byte (string/bytes payloads)
- in_last  in  1  word is the last of the message
- send_ring_data  out  8  byte to framing send ring
- send_ring_wr_en  out  1  ring write strobe
- send_ring_full  in  1  framing ring full
- send_fifo_data  out  LEN_BITS  payload length of the committed message
- send_fifo_wr_en  out  1  length FIFO write strobe
- send_fifo_full  in  1  length FIFO full
- error  out  1  sticky: a message exceeded MAX_PAYLOAD and was dropped
- busy  out  1  state != ST_COLLECT or buffer count != 0

Behaviour:
- Reset values:
  - in_ready = 1
  - send_ring_wr_en = 0, send_fifo_wr_en = 0, send_fifo_data = 0
  - error = 0, busy = 0
  - state = ST_COLLECT; buffer count, ovf flag and copy pointer all 0
- clr mid-message discards the partial payload. Bytes already written to the ring are not retracted, but no length is pushed for them.

States:
- ST_COLLECT
  - in_ready = 1.
  - On in_valid, latch data/raw/last and compute nbytes:
    - raw: 1
    - -32 ≤ v < 96: 1
    - -2^12 ≤ v < 3·2^12: 2
    - -2^19 ≤ v < 3·2^19: 3
    - -2^26 ≤ v < 3·2^26: 4
    - else: 5
  - Go to ST_ENCODE.
- ST_ENCODE
  - Emits one byte per cycle into the buffer, most significant group first.
  - Non-final bytes: ((v >> 7·k) & 0x7f) | 0x80, for k = nbytes-1 down to 1. The shift is arithmetic.
  - Final byte: v & 0x7f. Raw mode: v[7:0].
  - If the buffer count would exceed MAX_PAYLOAD, set the ovf flag and stop writing, but keep counting cycles.
  - After the final byte:
    - not last → ST_COLLECT
    - last and ovf → ST_DROP
    - last and no ovf → ST_COPY
- ST_COPY
  - send_ring_data = buf[rptr].
  - send_ring_wr_en = !send_ring_full, combinational; it is never asserted while full.
  - rptr advances on each write. When rptr == count after the last write → ST_LEN.
- ST_LEN
  - send_fifo_data = count.
  - send_fifo_wr_en = !send_fifo_full, asserted exactly one cycle.
  - Then clear count/rptr → ST_COLLECT.
- ST_DROP
  - Set error, clear count/ovf → ST_COLLECT.
  - Only clr clears error.

Timing and limits:
- Throughput is 1 byte/cycle.
- Latency from last word accept to first ring write: nbytes+1 cycles.
- A payload of exactly MAX_PAYLOAD bytes is legal. MAX_PAYLOAD+1 bytes is dropped.
- A message of only raw words is legal. There are no empty messages; every word yields ≥1 byte.
- The length push is held indefinitely while send_fifo_full is high; in_ready stays low meanwhile.

Optional Feature:
- MSG_ENCODER_STATS_EN
  - Defined: adds outputs stat_sent[15:0] and stat_dropped[15:0].
    - stat_sent increments on each send_fifo_wr_en; stat_dropped on each ST_DROP entry.
    - Both wrap at 0xffff and are cleared by clr.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package framing_pkg:
  - state enum ST_COLLECT/ST_ENCODE/ST_COPY/ST_LEN/ST_DROP
  - VLQ range threshold constants
  - FRAME_OVERHEAD = 5
  - MAX_FRAME_LEN = 63
- Sub-module vlq_len: combinational nbytes from a 32-bit signed value plus the raw flag. It is reused by the future receive-side decoder for range checks.

Test Plan:
- Single word 0, last → ring gets 0x00; fifo gets 1.
- Words 95, 96, -1, -33 (last on -33) → ring 0x5f, 0x80 0x60, 0x7f, 0xff 0x5f; fifo 6.
- Word 0x7fffffff, last → ring 0x87 0xff 0xff 0xff 0x7f; fifo 5. Word 0x80000000, last → ring 0xf8 0x80 0x80 0x80 0x00; fifo 5.
- Raw words 0x41, 0x142 (last) → ring 0x41 0x42; fifo 2. send_ring_full forced high for 10 cycles mid-copy → no wr_en while full; byte order is preserved.
- 12 five-byte words (60 bytes), last → no ring writes, no fifo write, error=1. A following 1-word message is still committed; clr → error=0.
- send_fifo_full held high 20 cycles at ST_LEN → in_ready=0 and exactly one send_fifo_wr_en after release.

Source files
------------

// File: rtl/framing_pkg.sv
// Shared definitions for the framing send/receive path: encoder states,
// VLQ range thresholds, frame sizing constants and the VLQ byte helper.
package framing_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_ENCODE,
        ST_COPY,
        ST_LEN,
        ST_DROP
    } enc_state_t;

    localparam int FRAME_OVERHEAD = 5;
    localparam int MAX_FRAME_LEN  = 63;

    // An n-byte VLQ covers [-2^(7n-2), 3*2^(7n-2)); five bytes cover everything else.
    localparam logic signed [31:0] VLQ1_LO = -32'sd32;
    localparam logic signed [31:0] VLQ1_HI = 32'sd96;
    localparam logic signed [31:0] VLQ2_LO = -32'sd4096;
    localparam logic signed [31:0] VLQ2_HI = 32'sd12288;
    localparam logic signed [31:0] VLQ3_LO = -32'sd524288;
    localparam logic signed [31:0] VLQ3_HI = 32'sd1572864;
    localparam logic signed [31:0] VLQ4_LO = -32'sd67108864;
    localparam logic signed [31:0] VLQ4_HI = 32'sd201326592;

    function automatic logic [7:0] vlqByte(input logic signed [31:0] value,
                                           input logic [2:0] group);
        logic signed [31:0] shifted;
        shifted = value >>> (32'(group) * 32'd7);
        return {group != 3'd0, shifted[6:0]};
    endfunction

endpackage

// File: rtl/vlq_len.sv
// Combinational byte count of a Klipper-style signed VLQ (or 1 for raw bytes).
// Shared with the receive-side decoder for range checks.
module vlq_len
    import framing_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic        i_raw,
    output logic [2:0]  o_nbytes
);

    logic signed [31:0] w_value;

    assign w_value = $signed(i_value);

    always_comb begin
        o_nbytes = 3'd5;
        if (i_raw) begin
            o_nbytes = 3'd1;
        end else if (w_value >= VLQ1_LO && w_value < VLQ1_HI) begin
            o_nbytes = 3'd1;
        end else if (w_value >= VLQ2_LO && w_value < VLQ2_HI) begin
            o_nbytes = 3'd2;
        end else if (w_value >= VLQ3_LO && w_value < VLQ3_HI) begin
            o_nbytes = 3'd3;
        end else if (w_value >= VLQ4_LO && w_value < VLQ4_HI) begin
            o_nbytes = 3'd4;
        end
    end

endmodule

// File: rtl/msg_encoder.sv
// Message encoder: VLQ-encodes argument words into a local payload buffer, then
// copies it to the send ring and pushes its length. Optional MSG_ENCODER_STATS_EN adds counters.
module msg_encoder
    import framing_pkg::*;
#(
    parameter int LEN_BITS    = 8,
    parameter int MAX_PAYLOAD = 58,
    parameter int BUF_BITS    = 6
)
(
    input  logic                clk,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  logic                in_raw,
    input  logic                in_last,
    output logic [7:0]          send_ring_data,
    output logic                send_ring_wr_en,
    input  logic                send_ring_full,
    output logic [LEN_BITS-1:0] send_fifo_data,
    output logic                send_fifo_wr_en,
    input  logic                send_fifo_full,
    output logic                error,
`ifdef MSG_ENCODER_STATS_EN
    output logic [15:0]         stat_sent,
    output logic [15:0]         stat_dropped,
`endif
    output logic                busy
);

    localparam int CNT_W = BUF_BITS + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

    enc_state_t         r_state;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_rptr;
    logic               r_ovf;
    logic               r_error;
    logic signed [31:0] r_data;
    logic               r_raw;
    logic               r_last;
    logic [2:0]         r_group;
    logic [7:0]         r_buf [2**BUF_BITS];

    logic [2:0]         w_nbytes;
    logic [7:0]         w_byte;
    logic               w_bufFull;
    logic               w_bufWe;
    logic [CNT_W-1:0]   w_rptrNext;

    vlq_len u_vlq_len (
        .i_value  (in_data),
        .i_raw    (in_raw),
        .o_nbytes (w_nbytes)
    );

    assign w_byte     = r_raw ? r_data[7:0] : vlqByte(r_data, r_group);
    assign w_bufFull  = (r_count == MAX_CNT);
    assign w_bufWe    = (r_state == ST_ENCODE) && !w_bufFull;
    assign w_rptrNext = r_rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_COLLECT;
            r_count <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
            r_error <= 1'b0;
            r_data  <= '0;
            r_raw   <= 1'b0;
            r_last  <= 1'b0;
            r_group <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (in_valid) begin
                        r_data  <= $signed(in_data);
                        r_raw   <= in_raw;
                        r_last  <= in_last;
                        r_group <= w_nbytes - 3'd1;
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    // Once full, bytes are discarded but the group walk continues to the word's end.
                    if (w_bufFull) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                    if (r_group == 3'd0) begin
                        if (!r_last) begin
                            r_state <= ST_COLLECT;
                        end else if (r_ovf || w_bufFull) begin
                            r_state <= ST_DROP;
                        end else begin
                            r_state <= ST_COPY;
                        end
                    end else begin
                        r_group <= r_group - 3'd1;
                    end
                end
                ST_COPY: begin
                    if (!send_ring_full) begin
                        r_rptr <= w_rptrNext;
                        if (w_rptrNext == r_count) begin
                            r_state <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    if (!send_fifo_full) begin
                        r_count <= '0;
                        r_rptr  <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_DROP: begin
                    r_error <= 1'b1;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= ST_COLLECT;
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    // Payload storage carries no reset; r_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_bufWe) begin
            r_buf[r_count[BUF_BITS-1:0]] <= w_byte;
        end
    end

    assign in_ready        = (r_state == ST_COLLECT);
    assign send_ring_data  = r_buf[r_rptr[BUF_BITS-1:0]];
    assign send_ring_wr_en = (r_state == ST_COPY) && !send_ring_full;
    assign send_fifo_data  = LEN_BITS'(r_count);
    assign send_fifo_wr_en = (r_state == ST_LEN) && !send_fifo_full;
    assign error           = r_error;
    assign busy            = (r_state != ST_COLLECT) || (r_count != '0);

`ifdef MSG_ENCODER_STATS_EN
    logic [15:0] r_statSent;
    logic [15:0] r_statDropped;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_statSent    <= '0;
            r_statDropped <= '0;
        end else begin
            if (send_fifo_wr_en) begin
                r_statSent <= r_statSent + 16'd1;
            end
            if (r_state == ST_DROP) begin
                r_statDropped <= r_statDropped + 16'd1;
            end
        end
    end

    assign stat_sent    = r_statSent;
    assign stat_dropped = r_statDropped;
`endif

endmodule

// File: tb/tb_msg_encoder.sv
// Scoreboard bench for msg_encoder: a high-level VLQ model fills expected queues,
// and a negedge monitor pops and compares every ring byte and length push.
module tb_msg_encoder;

    localparam int MAX_PAYLOAD = 58;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] inData = '0;
    logic        inRaw = 1'b0;
    logic        inLast = 1'b0;
    logic        ringFull = 1'b0;
    logic        fifoFull = 1'b0;
    logic        inReady;
    logic [7:0]  ringData;
    logic        ringWe;
    logic [7:0]  fifoData;
    logic        fifoWe;
    logic        error;
    logic        busy;
`ifdef MSG_ENCODER_STATS_EN
    logic [15:0] statSent;
    logic [15:0] statDropped;
`endif

    int checks = 0;
    int errors = 0;
    int ringWrites = 0;
    int fifoWrites = 0;
    int expSent = 0;
    int expDropped = 0;
    bit expError = 1'b0;
    bit monEnable = 1'b0;
    bit randFull = 1'b0;

    logic [7:0]  expRing[$];
    int          expLen[$];
    logic [7:0]  pendingBytes[$];
    logic [31:0] msgData[$];
    bit          msgRaw[$];

    msg_encoder dut (
        .clk             (clk),
        .clr             (clr),
        .in_valid        (inValid),
        .in_ready        (inReady),
        .in_data         (inData),
        .in_raw          (inRaw),
        .in_last         (inLast),
        .send_ring_data  (ringData),
        .send_ring_wr_en (ringWe),
        .send_ring_full  (ringFull),
        .send_fifo_data  (fifoData),
        .send_fifo_wr_en (fifoWe),
        .send_fifo_full  (fifoFull),
        .error           (error),
`ifdef MSG_ENCODER_STATS_EN
        .stat_sent       (statSent),
        .stat_dropped    (statDropped),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference encoder: n bytes is the smallest n with -2^(7n-2) <= v < 3*2^(7n-2), capped at 5.
    function automatic void encodeWord(input logic [31:0] d, input bit raw);
        longint v;
        longint lim;
        int n;
        if (raw) begin
            pendingBytes.push_back(d[7:0]);
            return;
        end
        v = longint'($signed(d));
        n = 5;
        for (int i = 4; i >= 1; i--) begin
            lim = longint'(1) << (7 * i - 2);
            if (v >= -lim && v < 3 * lim) n = i;
        end
        for (int k = n - 1; k >= 0; k--) begin
            longint g;
            g = (v >>> (7 * k)) & 64'h7f;
            pendingBytes.push_back(8'(g) | ((k != 0) ? 8'h80 : 8'h00));
        end
    endfunction

    task automatic addWord(input logic [31:0] d, input bit raw);
        msgData.push_back(d);
        msgRaw.push_back(raw);
    endtask

    task automatic applyStimulus(input logic [31:0] d, input bit raw, input bit last);
        int n = 0;
        @(negedge clk);
        while (!inReady && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=0 expected 1 within 2000 cycles");
        end
        inValid = 1'b1;
        inData  = d;
        inRaw   = raw;
        inLast  = last;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // Sends the queued words as one message and commits the model's expectation.
    task automatic sendMsg();
        pendingBytes.delete();
        for (int i = 0; i < msgData.size(); i++) begin
            encodeWord(msgData[i], msgRaw[i]);
            applyStimulus(msgData[i], msgRaw[i], i == msgData.size() - 1);
        end
        if (pendingBytes.size() <= MAX_PAYLOAD) begin
            foreach (pendingBytes[j]) expRing.push_back(pendingBytes[j]);
            expLen.push_back(pendingBytes.size());
            expSent++;
        end else begin
            expError = 1'b1;
            expDropped++;
        end
        msgData.delete();
        msgRaw.delete();
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((busy || !inReady || expRing.size() != 0 || expLen.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=%0d ring_left=%0d len_left=%0d expected idle",
                     busy, expRing.size(), expLen.size());
        end
    endtask

    task automatic checkResetState(input string tag);
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, 32'(inReady), 32'd1);
        checkOutput({tag, "_ring_we"}, 32'(ringWe), 32'd0);
        checkOutput({tag, "_fifo_we"}, 32'(fifoWe), 32'd0);
        checkOutput({tag, "_fifo_data"}, 32'(fifoData), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every strobe seen mid-cycle is a transfer at the next rising edge.
    always @(negedge clk) begin
        if (monEnable) begin
            if (ringFull) checkOutput("ring_we_while_full", 32'(ringWe), 32'd0);
            if (fifoFull) checkOutput("fifo_we_while_full", 32'(fifoWe), 32'd0);
            if (ringWe) begin
                ringWrites++;
                if (expRing.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL ring_unexpected: got byte 0x%0h expected no write", ringData);
                end else begin
                    checkOutput("ring_byte", 32'(ringData), 32'(expRing.pop_front()));
                end
            end
            if (fifoWe) begin
                fifoWrites++;
                if (expLen.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL fifo_unexpected: got len %0d expected no write", fifoData);
                end else begin
                    checkOutput("fifo_len", 32'(fifoData), 32'(expLen.pop_front()));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (randFull) begin
            #1;
            ringFull = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        int ringBefore;
        int fifoBefore;
        int n;

        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        checkResetState("reset");
        monEnable = 1'b1;

        addWord(32'd0, 1'b0);
        sendMsg();
        waitIdle();

        addWord(32'd95, 1'b0);
        addWord(32'd96, 1'b0);
        addWord(32'hffff_ffff, 1'b0);
        addWord(32'(-33), 1'b0);
        sendMsg();
        waitIdle();

        addWord(32'h7fff_ffff, 1'b0);
        sendMsg();
        addWord(32'h8000_0000, 1'b0);
        sendMsg();
        waitIdle();

        // Ring backpressure after the first copied byte.
        addWord(32'h41, 1'b1);
        addWord(32'h142, 1'b1);
        sendMsg();
        n = 0;
        @(negedge clk);
        while (!ringWe && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ring_copy_started", 32'(ringWe), 32'd1);
        @(posedge clk);
        #1;
        ringFull = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        ringFull = 1'b0;
        waitIdle();

        // Length push held while the FIFO is full.
        fifoBefore = fifoWrites;
        @(posedge clk);
        #1;
        fifoFull = 1'b1;
        addWord(32'd5000, 1'b0);
        sendMsg();
        repeat (20) begin
            @(negedge clk);
            checkOutput("in_ready_held", 32'(inReady), 32'd0);
        end
        checkOutput("fifo_held_no_push", 32'(fifoWrites - fifoBefore), 32'd0);
        @(posedge clk);
        #1;
        fifoFull = 1'b0;
        waitIdle();
        checkOutput("fifo_push_once", 32'(fifoWrites - fifoBefore), 32'd1);

        // Exactly MAX_PAYLOAD bytes is committed.
        for (int i = 0; i < 11; i++) addWord(32'h7fff_ffff, 1'b0);
        for (int i = 0; i < 3; i++) addWord(32'h30 + 32'(i), 1'b1);
        sendMsg();
        waitIdle();
        checkOutput("max_payload_error", 32'(error), 32'd0);

        // One byte over is dropped whole.
        ringBefore = ringWrites;
        fifoBefore = fifoWrites;
        for (int i = 0; i < 11; i++) addWord(32'h7fff_ffff, 1'b0);
        for (int i = 0; i < 4; i++) addWord(32'h30 + 32'(i), 1'b1);
        sendMsg();
        waitIdle();
        checkOutput("drop59_error", 32'(error), 32'(expError));

        for (int i = 0; i < 12; i++) addWord(32'h8000_0000, 1'b0);
        sendMsg();
        waitIdle();
        checkOutput("drop60_error", 32'(error), 32'd1);
        checkOutput("drop_no_ring", 32'(ringWrites - ringBefore), 32'd0);
        checkOutput("drop_no_fifo", 32'(fifoWrites - fifoBefore), 32'd0);

        addWord(32'(-5), 1'b0);
        sendMsg();
        waitIdle();
        checkOutput("error_sticky", 32'(error), 32'd1);
        checkOutput("after_drop_fifo", 32'(fifoWrites - fifoBefore), 32'd1);
`ifdef MSG_ENCODER_STATS_EN
        checkOutput("stat_sent", 32'(statSent), 32'(expSent));
        checkOutput("stat_dropped", 32'(statDropped), 32'(expDropped));
`endif

        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        expError = 1'b0;
        expSent = 0;
        expDropped = 0;
        checkResetState("clr");

        // Randomised back-to-back messages under random ring backpressure.
        randFull = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int words;
            words = $urandom_range(1, 8);
            for (int w = 0; w < words; w++) begin
                logic signed [31:0] r;
                r = $signed($urandom);
                r = r >>> $urandom_range(0, 31);
                addWord(r, $urandom_range(0, 3) == 0);
            end
            sendMsg();
        end
        waitIdle();
        randFull = 1'b0;
        @(posedge clk);
        #1;
        ringFull = 1'b0;
        waitIdle();
        checkOutput("random_error", 32'(error), 32'(expError));
        checkOutput("random_ring_left", 32'(expRing.size()), 32'd0);
        checkOutput("random_len_left", 32'(expLen.size()), 32'd0);
`ifdef MSG_ENCODER_STATS_EN
        checkOutput("random_stat_sent", 32'(statSent), 32'(expSent));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
